// File: rtl/bufm_id_mgr.sv
// Buffer-ID free-list manager shared by the ingress and egress buffer managers.
// Optional BUFM_DUP_CHECK_EN adds an in-use bitmap that rejects double/unknown releases.
module bufm_id_mgr #(
    parameter int ID_NUM    = 32,
    parameter int ID_WIDTH  = 8,
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_alloc_req,
    output logic [ID_WIDTH-1:0]  out_alloc_id,
    output logic                 out_alloc_id_wr,
    output logic                 out_alloc_fail,
    input  logic [ID_WIDTH-1:0]  in_release_id,
    input  logic                 in_release_id_wr,
    output logic                 out_release_err,
    input  logic                 in_flush,
    output logic [CNT_WIDTH-1:0] out_free_cnt,
    output logic                 out_init_done
);

    localparam int                   PTR_W    = (ID_NUM > 1) ? $clog2(ID_NUM) : 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(ID_NUM);
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(ID_NUM - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state;
    logic [ID_WIDTH-1:0]  id_mem [ID_NUM];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_WIDTH-1:0] free_cnt;
    logic [ID_WIDTH-1:0]  head_id;
    logic                 id_in_range;
    logic                 rel_in_use;
    logic                 alloc_ok;
    logic                 rel_ok;
    logic                 mem_we;
    logic [ID_WIDTH-1:0]  mem_wdata;

    assign head_id      = id_mem[rd_ptr];
    assign id_in_range  = (32'(in_release_id) < 32'(ID_NUM));
    assign out_free_cnt = free_cnt;

`ifdef BUFM_DUP_CHECK_EN
    logic [ID_NUM-1:0] in_use;
    logic [PTR_W-1:0]  rel_idx;

    assign rel_idx    = in_release_id[PTR_W-1:0];
    assign rel_in_use = in_use[rel_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_use <= '0;
        end else if (in_flush || state == ST_INIT) begin
            in_use <= '0;
        end else begin
            if (alloc_ok) begin
                in_use[head_id[PTR_W-1:0]] <= 1'b1;
            end
            if (rel_ok) begin
                in_use[rel_idx] <= 1'b0;
            end
        end
    end
`else
    assign rel_in_use = 1'b1;
`endif

    // An empty list never bypasses a same-cycle release into the grant path.
    always_comb begin
        alloc_ok  = 1'b0;
        rel_ok    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = in_release_id;
        if (!in_flush) begin
            if (state == ST_INIT) begin
                mem_we    = 1'b1;
                mem_wdata = ID_WIDTH'(wr_ptr);
            end else begin
                alloc_ok = in_alloc_req && (free_cnt != '0);
                rel_ok   = in_release_id_wr && id_in_range &&
                           (free_cnt != FULL_CNT) && rel_in_use;
                mem_we   = rel_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            id_mem[wr_ptr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_INIT;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            free_cnt        <= '0;
            out_alloc_id    <= '0;
            out_alloc_id_wr <= 1'b0;
            out_alloc_fail  <= 1'b0;
            out_release_err <= 1'b0;
            out_init_done   <= 1'b0;
        end else begin
            out_alloc_id_wr <= alloc_ok;
            out_alloc_fail  <= in_alloc_req && !alloc_ok && !in_flush;
            out_release_err <= in_release_id_wr && !rel_ok && !in_flush;
            if (alloc_ok) begin
                out_alloc_id <= head_id;
            end
            if (in_flush) begin
                state         <= ST_INIT;
                rd_ptr        <= '0;
                wr_ptr        <= '0;
                free_cnt      <= '0;
                out_init_done <= 1'b0;
            end else if (state == ST_INIT) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == LAST_PTR) begin
                    state         <= ST_RUN;
                    free_cnt      <= FULL_CNT;
                    out_init_done <= 1'b1;
                end
            end else begin
                if (alloc_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (rel_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                unique case ({alloc_ok, rel_ok})
                    2'b10:   free_cnt <= free_cnt - 1'b1;
                    2'b01:   free_cnt <= free_cnt + 1'b1;
                    default: free_cnt <= free_cnt;
                endcase
            end
        end
    end

endmodule

// File: doc/bufm_id_mgr.md
# bufm_id_mgr

Buffer-ID manager for the TSN switch packet buffer shared by the ingress buffer manager (ibm) and the egress buffer manager (ebm). It holds a free list of buffer IDs, grants one ID per allocation request from the ingress side, and takes back IDs that the egress side has finished reading out. It also reports the free-ID count that the ingress side and the lcm use for admission control and counters.

## Interface
Parameters:
- ID_NUM, 32, number of buffer IDs; must be a power of two, 2..256
- ID_WIDTH, 8, width of an ID
- CNT_WIDTH, 6, width of the free count; must hold the value ID_NUM

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- in_alloc_req  in  1  one-cycle pulse requesting one ID
- out_alloc_id  out  ID_WIDTH  granted ID; valid only while out_alloc_id_wr is high
- out_alloc_id_wr  out  1  grant strobe
- out_alloc_fail  out  1  pulse: request refused because the list is empty or initialising
- in_release_id  in  ID_WIDTH  ID being returned
- in_release_id_wr  in  1  release strobe
- out_release_err  out  1  pulse: release was dropped
- in_flush  in  1  pulse: synchronous re-initialisation
- out_free_cnt  out  CNT_WIDTH  number of free IDs
- out_init_done  out  1  high when the free list is usable

## Operation
- Free list: circular FIFO of ID_NUM entries. rd_ptr and wr_ptr are log2(ID_NUM) bits wide and wrap naturally. Count is held in free_cnt.
- FSM states: INIT and RUN.
- INIT
  - Entered from reset and from in_flush. in_flush is honoured in any state.
  - Writes IDs 0..ID_NUM-1 one per cycle in ascending order. Pointers and count start at 0.
  - Moves to RUN after the last write; free_cnt = ID_NUM at that point.
  - Any alloc request in INIT produces out_alloc_fail.
  - Any release in INIT is dropped and produces out_release_err.
- RUN, allocation
  - in_alloc_req with free_cnt > 0: pop the entry at rd_ptr, then rd_ptr+1 and free_cnt-1.
  - in_alloc_req with free_cnt = 0: out_alloc_fail; no state change.
- RUN, release
  - Accepted: push at wr_ptr, then wr_ptr+1 and free_cnt+1.
  - Dropped with out_release_err when the ID is ≥ ID_NUM or free_cnt = ID_NUM.
- Same cycle alloc and release, both legal: both are served and free_cnt is unchanged.
- Same cycle alloc and release with free_cnt = 0: the alloc fails (no bypass), the release is accepted, and free_cnt becomes 1.
- in_flush takes priority over alloc and release in the same cycle. Those requests are neither granted nor flagged.

## Timing
- Reset values: every output is 0, including out_init_done and out_free_cnt. The FSM resets to INIT.
- Initialisation:
  - First write happens in the first clock edge after rst_n deasserts.
  - out_init_done rises ID_NUM cycles later, together with out_free_cnt = ID_NUM.
  - in_flush clears out_init_done and out_free_cnt on the next edge, then the same ID_NUM-cycle sequence runs.
- Allocation latency: request sampled at edge t; out_alloc_id_wr / out_alloc_id or out_alloc_fail is high for exactly one cycle after edge t.
- Release: sampled at edge t; out_release_err is reported and out_free_cnt is updated after edge t.
- out_free_cnt is registered and reflects all operations sampled at the previous edge.
- Throughput: one alloc plus one release per cycle, sustained.

## Configuration
- BUFM_DUP_CHECK_EN defined:
  - Adds an ID_NUM-bit in-use bitmap. A bit is set on grant and cleared on an accepted release; all bits are cleared in INIT.
  - A release of an ID whose bit is clear (double free or never allocated) is dropped with out_release_err.
  - Same-cycle grant and release of the same ID cannot occur, because a granted ID is in use.
- BUFM_DUP_CHECK_EN undefined:
  - No bitmap. Only the range check and the full check apply.
  - Duplicate releases are accepted and can corrupt the list; upstream correctness is relied on.

## Test plan
- Reset, then idle 40 cycles. out_init_done rises exactly 32 cycles after rst_n release with out_free_cnt = 32. Issue 32 allocs: grants are IDs 0..31 in order, and a 33rd alloc gives out_alloc_fail.
- Empty list. Release ID 7 and alloc in the same cycle: alloc fails, free_cnt = 1. Next alloc grants 7 and free_cnt = 0.
- Full list. Release ID 3: out_release_err pulses and free_cnt stays 32. Release ID 40: out_release_err pulses.
- Alloc 5 IDs (0..4), release 2,0,4, alloc 3 IDs. Grants are 5,6,7 (FIFO order), free_cnt = 27. Run 200 random cycles checking against a scoreboard, including pointer wrap.
- in_flush with 10 IDs outstanding. out_init_done drops next cycle; an alloc during INIT fails; after 32 cycles free_cnt = 32 and the first grant is 0.
- With BUFM_DUP_CHECK_EN: alloc ID 0, release 0 twice. The second release gives out_release_err and free_cnt = 32. Without the macro, the same sequence on a list that is not full is accepted.
